mem_arbiter_n: RTL and testbench

- N-port generalisation of the CPU's two-port instruction/data memory arbiter, sitting between pipeline requesters and one single-port synchronous memory.
- Requesters are instruction fetch, data access and future DMA/debug ports.
- Adds selectable fixed or round-robin priority, per-port lock for atomic sequences, and read-return tagging through a latency pipeline.
- Each read result is delivered only to the port that issued it.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arbiter_n_rr_arbiter.sv | 37 +++
 rtl/mem_arbiter_n.sv | 103 ++++++++++
 tb/tb_mem_arbiter_n.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and sizing helpers for the N-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
  localparam int READ_LATENCY_MAX = 4;
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arbiter_n_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant picker with fixed/round-robin priority and lock override.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = port_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  arb_mode_e     mode,
  input  logic [IW-1:0] pointer,
  input  logic [IW-1:0] lock_owner,
  input  logic          lock_valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic          found;
  logic [IW-1:0] cand;
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (lock_valid && req[lock_owner]) begin
      grant_idx = lock_owner;
      found     = 1'b1;
    end else begin
      // fixed mode scans 0..N-1; round-robin scans pointer+1 onwards with wrap
      for (int k = 1; k <= N; k++) begin
        cand = (mode == ARB_FIXED) ? IW'(k - 1) : IW'((int'(pointer) + k) % N);
        if (!found && req[cand]) begin
          grant_idx = cand;
          found     = 1'b1;
        end
      end
    end
    grant = found ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port arbiter in front of one single-port synchronous memory,
// with lock support and port-tagged read returns through a latency pipeline.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int        NUM_PORTS    = 2,
  parameter int        ADDR_WIDTH   = 8,
  parameter int        DATA_WIDTH   = 16,
  parameter arb_mode_e ARB_MODE     = ARB_RR,
  parameter int        READ_LATENCY = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS-1:0]             lock_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_value_o,
  output logic                             mem_re_o,
  output logic                             mem_we_o,
  output logic                             mem_enable_o,
  input  logic [DATA_WIDTH-1:0]            mem_value_i
);
  localparam int IW = port_idx_w(NUM_PORTS);
  localparam int PW = READ_LATENCY * IW;
  logic [NUM_PORTS-1:0]    gnt, rvalid_q, rvalid_d;
  logic [IW-1:0]           gnt_idx, owner_q, owner_d, ptr_q, ptr_d, iss_q, iss_d;
  logic                    any, lock_hit, lock_q, lock_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_value_q, mem_value_d, rdata_q, rdata_d;
  logic                    mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [PW-1:0]           pp_q, pp_d;
  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .req        (req_i),
    .mode       (ARB_MODE),
    .pointer    (ptr_q),
    .lock_owner (owner_q),
    .lock_valid (lock_q),
    .grant      (gnt),
    .grant_idx  (gnt_idx)
  );
  always_comb begin
    any         = |req_i;
    lock_hit    = lock_q && req_i[owner_q];
    lock_d      = lock_hit;
    owner_d     = any ? gnt_idx : owner_q;
    ptr_d       = (any && !lock_hit) ? gnt_idx : ptr_q;
    iss_d       = any ? gnt_idx : iss_q;
    if (any) lock_d = lock_i[gnt_idx];
    mem_re_d    = any && !we_i[gnt_idx];
    mem_we_d    = any && we_i[gnt_idx];
    mem_addr_d  = any ? addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : mem_addr_q;
    mem_value_d = any ? wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : mem_value_q;
    // tag pipeline shifts up by one stage per cycle; the top stage lines up with mem_value_i
    pv_d        = READ_LATENCY'({pv_q, mem_re_q});
    pp_d        = PW'({pp_q, iss_q});
    rvalid_d    = pv_q[READ_LATENCY-1] ? NUM_PORTS'(1) << pp_q[(READ_LATENCY-1)*IW +: IW] : '0;
    rdata_d     = pv_q[READ_LATENCY-1] ? mem_value_i : rdata_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lock_q      <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= IW'(NUM_PORTS - 1);
      iss_q       <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_value_q <= '0;
      pv_q        <= '0;
      pp_q        <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      iss_q       <= iss_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_value_q <= mem_value_d;
      pv_q        <= pv_d;
      pp_q        <= pp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end
  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_value_o  = mem_value_q;
  assign mem_re_o     = mem_re_q;
  assign mem_we_o     = mem_we_q;
  assign mem_enable_o = mem_re_q | mem_we_q;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed table-driven checks of mem_arbiter_n across modes, port counts and latencies.
module tb_mem_arbiter_n;
  import mem_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req, we, lock;
  logic [15:0] addr, mv;
  logic [31:0] wdata;
  logic [1:0] r_gnt, r_rv, f_gnt, f_rv, l_gnt, l_rv;
  logic [15:0] r_rd, r_mval, f_rd, f_mval, l_rd, l_mval;
  logic [7:0] r_ma, f_ma, l_ma;
  logic r_re, r_we, r_en, f_re, f_we, f_en, l_re, l_we, l_en;
  logic [2:0] t_req, t_we, t_lock, t_gnt, t_rv;
  logic [23:0] t_addr;
  logic [47:0] t_wdata;
  logic [15:0] t_mv, t_rd, t_mval;
  logic [7:0] t_ma;
  logic t_re, t_wem, t_en;
  int n_cmp = 0;
  int n_fail = 0;
  mem_arbiter_n #(.NUM_PORTS(2), .ARB_MODE(ARB_RR), .READ_LATENCY(1)) u_rr (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .lock_i(lock), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(r_gnt), .rvalid_o(r_rv), .rdata_o(r_rd), .mem_addr_o(r_ma), .mem_value_o(r_mval),
    .mem_re_o(r_re), .mem_we_o(r_we), .mem_enable_o(r_en), .mem_value_i(mv));
  mem_arbiter_n #(.NUM_PORTS(2), .ARB_MODE(ARB_FIXED), .READ_LATENCY(1)) u_fx (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .lock_i(lock), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(f_gnt), .rvalid_o(f_rv), .rdata_o(f_rd), .mem_addr_o(f_ma), .mem_value_o(f_mval),
    .mem_re_o(f_re), .mem_we_o(f_we), .mem_enable_o(f_en), .mem_value_i(mv));
  mem_arbiter_n #(.NUM_PORTS(2), .ARB_MODE(ARB_RR), .READ_LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .lock_i(lock), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(l_gnt), .rvalid_o(l_rv), .rdata_o(l_rd), .mem_addr_o(l_ma), .mem_value_o(l_mval),
    .mem_re_o(l_re), .mem_we_o(l_we), .mem_enable_o(l_en), .mem_value_i(mv));
  mem_arbiter_n #(.NUM_PORTS(3), .ARB_MODE(ARB_RR), .READ_LATENCY(1)) u_n3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(t_req), .we_i(t_we), .lock_i(t_lock), .addr_i(t_addr), .wdata_i(t_wdata),
    .gnt_o(t_gnt), .rvalid_o(t_rv), .rdata_o(t_rd), .mem_addr_o(t_ma), .mem_value_o(t_mval),
    .mem_re_o(t_re), .mem_we_o(t_wem), .mem_enable_o(t_en), .mem_value_i(t_mv));
  typedef struct {
    logic [1:0] req, we;
    logic [7:0] a0, a1;
    logic [15:0] wd0, mv;
    logic [1:0] gnt, rv;
    logic [15:0] rd;
    logic [7:0] ma;
    logic [15:0] mval;
    logic re, wem;
  } vec_t;
  vec_t vt [11];
  logic [2:0] s_req [8], s_lock [8], s_gnt [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] rq, input logic [1:0] w, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [15:0] wd0, input logic [15:0] m);
    req = rq; we = w; lock = 2'b00; addr = {a1, a0}; wdata = {16'h0, wd0}; mv = m;
  endtask
  initial begin
    vt[0]  = '{2'b11, 2'b00, 8'h10, 8'h20, 16'h0000, 16'h0000, 2'b01, 2'b00, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{2'b11, 2'b00, 8'h10, 8'h20, 16'h0000, 16'h0000, 2'b10, 2'b00, 16'h0000, 8'h10, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{2'b11, 2'b00, 8'h10, 8'h20, 16'h0000, 16'h1111, 2'b01, 2'b00, 16'h0000, 8'h20, 16'h0000, 1'b1, 1'b0};
    vt[3]  = '{2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 16'h2222, 2'b00, 2'b01, 16'h1111, 8'h10, 16'h0000, 1'b1, 1'b0};
    vt[4]  = '{2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 16'h3333, 2'b00, 2'b10, 16'h2222, 8'h10, 16'h0000, 1'b0, 1'b0};
    vt[5]  = '{2'b00, 2'b00, 8'h10, 8'h20, 16'h0000, 16'h0000, 2'b00, 2'b01, 16'h3333, 8'h10, 16'h0000, 1'b0, 1'b0};
    vt[6]  = '{2'b10, 2'b00, 8'h10, 8'h05, 16'h0000, 16'h0000, 2'b10, 2'b00, 16'h3333, 8'h10, 16'h0000, 1'b0, 1'b0};
    vt[7]  = '{2'b00, 2'b00, 8'h10, 8'h05, 16'h0000, 16'h0000, 2'b00, 2'b00, 16'h3333, 8'h05, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{2'b01, 2'b01, 8'h33, 8'h05, 16'h1234, 16'hBEEF, 2'b01, 2'b00, 16'h3333, 8'h05, 16'h0000, 1'b0, 1'b0};
    vt[9]  = '{2'b00, 2'b00, 8'h33, 8'h05, 16'h1234, 16'h0000, 2'b00, 2'b10, 16'hBEEF, 8'h33, 16'h1234, 1'b0, 1'b1};
    vt[10] = '{2'b00, 2'b00, 8'h33, 8'h05, 16'h1234, 16'h0000, 2'b00, 2'b00, 16'hBEEF, 8'h33, 16'h1234, 1'b0, 1'b0};
    s_req  = '{3'b100, 3'b111, 3'b111, 3'b011, 3'b011, 3'b010, 3'b000, 3'b111};
    s_lock = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
    s_gnt  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b010, 3'b000, 3'b100};
    drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    t_req = '0; t_we = '0; t_lock = '0; t_addr = 24'h302010; t_wdata = '0; t_mv = '0;
    #12;
    chk("reset gnt", 32'(r_gnt), 32'h0);
    chk("reset rvalid", 32'(r_rv), 32'h0);
    chk("reset rdata", 32'(r_rd), 32'h0);
    chk("reset mem_addr", 32'(r_ma), 32'h0);
    chk("reset strobes", 32'({r_re, r_we, r_en}), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].we, vt[i].a0, vt[i].a1, vt[i].wd0, vt[i].mv);
      #1;
      chk($sformatf("v%0d gnt", i), 32'(r_gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d rvalid", i), 32'(r_rv), 32'(vt[i].rv));
      chk($sformatf("v%0d rdata", i), 32'(r_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d mem_addr", i), 32'(r_ma), 32'(vt[i].ma));
      chk($sformatf("v%0d mem_value", i), 32'(r_mval), 32'(vt[i].mval));
      chk($sformatf("v%0d mem_re", i), 32'(r_re), 32'(vt[i].re));
      chk($sformatf("v%0d mem_we", i), 32'(r_we), 32'(vt[i].wem));
      chk($sformatf("v%0d mem_enable", i), 32'(r_en), 32'(vt[i].re | vt[i].wem));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 8'h10, 8'h20, 16'h0, 16'h0);
      #1 chk($sformatf("fixed hold %0d gnt", i), 32'(f_gnt), 32'h1);
    end
    @(negedge clk);
    drive(2'b10, 2'b00, 8'h10, 8'h20, 16'h0, 16'h0);
    #1 chk("fixed drop0 gnt", 32'(f_gnt), 32'h2);
    @(negedge clk);
    drive(2'b00, 2'b00, 8'h10, 8'h20, 16'h0, 16'h0);
    #1 chk("fixed drop0 mem_addr", 32'(f_ma), 32'h20);
    chk("fixed drop0 mem_re", 32'(f_re), 32'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      t_req = s_req[i]; t_lock = s_lock[i];
      #1 chk($sformatf("n3 lock step %0d gnt", i), 32'(t_gnt), 32'(s_gnt[i]));
    end
    @(negedge clk);
    t_req = '0; t_lock = '0;
    #1 chk("n3 last mem_addr", 32'(t_ma), 32'h30);
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h40, 8'h41, 16'h0, 16'hAAAA);
    #1 chk("l3 gnt", 32'(l_gnt), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(2'b00, 2'b00, 8'h40, 8'h41, 16'h0, 16'hAAAA);
      #1 chk($sformatf("l3 N+%0d rvalid", i), 32'(l_rv), 32'h0);
    end
    @(negedge clk) #1;
    chk("l3 N+5 rvalid", 32'(l_rv), 32'h1);
    chk("l3 N+5 rdata", 32'(l_rd), 32'hAAAA);
    @(negedge clk) #1;
    chk("l3 N+6 rvalid", 32'(l_rv), 32'h0);
    @(negedge clk);
    drive(2'b01, 2'b00, 8'h40, 8'h41, 16'h0, 16'hAAAA);
    @(negedge clk);
    drive(2'b10, 2'b00, 8'h40, 8'h41, 16'h0, 16'hAAAA);
    #1 chk("l3 pre-reset mem_re", 32'(l_re), 32'h1);
    @(negedge clk);
    drive(2'b00, 2'b00, 8'h40, 8'h41, 16'h0, 16'hAAAA);
    rst_n = 1'b0;
    #1;
    chk("l3 reset gnt", 32'(l_gnt), 32'h0);
    chk("l3 reset strobes", 32'({l_re, l_we, l_en}), 32'h0);
    chk("l3 reset mem_addr", 32'(l_ma), 32'h0);
    chk("l3 reset mem_value", 32'(l_mval), 32'h0);
    chk("l3 reset rvalid", 32'(l_rv), 32'h0);
    chk("l3 reset rdata", 32'(l_rd), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) #1;
      chk($sformatf("l3 post-reset %0d rvalid", i), 32'(l_rv), 32'h0);
      chk($sformatf("l3 post-reset %0d rdata", i), 32'(l_rd), 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
